layer_compositor: RTL
=====================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, number of sprite/tile layers; legal range 2..16.
REQ-002 SHALL have parameter COLOR_W, default 12, packed {R,G,B} pixel width (4:4:4 at default).
REQ-003 SHALL have parameter BG_COLOR, default 12'h0F0, colour shown where no layer is enabled.
REQ-004 SHALL have parameter IDX_W, default 3, width of layer index; SHALL be at least ceil(log2(NUM_LAYERS+1)).
REQ-005 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 layer_rgb  input  NUM_LAYERS*COLOR_W  per-layer colour; layer k occupies bits [k*COLOR_W +: COLOR_W].
REQ-008 layer_en  input  NUM_LAYERS  per-layer pixel-on flag for the current pixel.
REQ-009 bright  input  1  display-active flag for the current pixel.
REQ-010 frame_start  input  1  one-cycle pulse at start of each frame (vertical sync edge).
REQ-011 layer_mask  input  NUM_LAYERS  requested layer visibility; sampled only at frame_start.
REQ-012 vga_rgb  output  COLOR_W  registered composited pixel.
REQ-013 top_layer  output  IDX_W  registered index of the winning layer; NUM_LAYERS when background.
REQ-014 collision_flags  output  NUM_LAYERS-1  bit k-1 set if layer 0 overlapped layer k during the previous frame.
REQ-015 collision_valid  output  1  one-cycle pulse when collision_flags is updated.

Function
REQ-016 Active mask SHALL be a shadow register loaded from layer_mask on a cycle where frame_start=1; mask changes between pulses SHALL have no effect.
REQ-017 Effective enable SHALL be layer_en AND active mask.
REQ-018 Priority SHALL be fixed: lowest index wins (layer 0 = player, highest); any number of simultaneous enables SHALL be legal.
REQ-019 Stage 1 (cycle N+1) SHALL register: winning colour (BG_COLOR if no effective enable), winning index, and bright.
REQ-020 Stage 2 (cycle N+2) SHALL drive vga_rgb = stage-1 colour if stage-1 bright=1, else all zeros; top_layer SHALL follow with the same 2-cycle latency and read NUM_LAYERS when bright=0.
REQ-021 Latency from layer_rgb/layer_en/bright to vga_rgb SHALL be exactly 2 cycles, throughput one pixel per cycle, no stalls.
REQ-022 Sticky collision register: on any cycle with bright=1 and effective en[0]=1 and effective en[k]=1 (k>=1), bit k-1 SHALL be set.
REQ-023 On frame_start=1: collision_flags SHALL load sticky OR same-cycle hits; sticky SHALL clear to zero (same-cycle hits not carried over); collision_valid SHALL pulse high for exactly the following cycle.
REQ-024 Collisions SHALL use the mask active on the cycle of the hit (the shadow mask, not the incoming layer_mask).
REQ-025 Back-to-back frame_start pulses SHALL each produce a collision_valid pulse; a second pulse reports only hits seen since the first.
REQ-026 collision_flags SHALL hold its value between frame_start pulses.
REQ-027 Masked-off layers SHALL neither display nor register collisions; a fully masked frame SHALL show BG_COLOR during bright.

Reset
REQ-028 On clk edge with reset_n=0: vga_rgb=0, top_layer=NUM_LAYERS, pipeline bright=0, collision_flags=0, sticky=0, collision_valid=0, active mask=all ones.
REQ-029 Reset SHALL override a coincident frame_start; pipeline contents in flight SHALL be discarded, first valid pixel appearing 2 cycles after release.

Verification
REQ-030 Only layer 3 enabled, colour 12'hABC, bright=1, mask all ones -> vga_rgb=12'hABC, top_layer=3 exactly 2 cycles later.
REQ-031 Layers 0 (12'hF00) and 4 (12'h00F) both enabled -> vga_rgb=12'hF00, top_layer=0; on next frame_start collision_flags=5'b01000, collision_valid one-cycle pulse.
REQ-032 No layer enabled, bright=1 -> vga_rgb=12'h0F0, top_layer=6; same with bright=0 -> vga_rgb=0.
REQ-033 layer_mask=6'b111110 driven mid-frame, layer 0 enabled -> layer 0 still shown until frame_start; after it, background shown and no collisions recorded.
REQ-034 Layer 0 and layer 1 overlap only on the frame_start cycle -> that pulse's flags=5'b00001; next pulse flags=0.
REQ-035 reset_n=0 asserted mid-frame with sticky bits set and frame_start coincident -> all outputs at reset values, no collision_valid pulse, flags=0 after release.

Source files
------------

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - priority layer compositor with 2-stage pixel pipe and per-frame collision report
module layer_compositor #(
  parameter int                 NUM_LAYERS = 6,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h0F0,
  parameter int                 IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          bright,
  input  logic                          frame_start,
  input  logic [NUM_LAYERS-1:0]         layer_mask,
  output logic [COLOR_W-1:0]            vga_rgb,
  output logic [IDX_W-1:0]              top_layer,
  output logic [NUM_LAYERS-2:0]         collision_flags,
  output logic                          collision_valid
);

  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [NUM_LAYERS-1:0] eff_en;
  logic [COLOR_W-1:0]    win_rgb;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_LAYERS-2:0] hits;

  logic [COLOR_W-1:0]    s1_rgb_q;
  logic [IDX_W-1:0]      s1_idx_q;
  logic                  s1_bright_q;
  logic [COLOR_W-1:0]    vga_rgb_q, vga_rgb_d;
  logic [IDX_W-1:0]      top_layer_q, top_layer_d;

  logic [NUM_LAYERS-2:0] sticky_q, sticky_d;
  logic [NUM_LAYERS-2:0] flags_q, flags_d;
  logic                  valid_q;

  // The shadow mask only changes at a frame boundary; the frame_start cycle itself still uses the old mask.
  assign mask_d = frame_start ? layer_mask : mask_q;
  assign eff_en = layer_en & mask_q;

  // Walk from the highest index down so the lowest enabled index is the last writer.
  always_comb begin
    win_rgb = BG_COLOR;
    win_idx = BG_IDX;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (eff_en[k]) begin
        win_rgb = layer_rgb[k*COLOR_W +: COLOR_W];
        win_idx = IDX_W'(k);
      end
    end
  end

  assign hits = bright ? (eff_en[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){eff_en[0]}}) : '0;

  always_comb begin
    vga_rgb_d   = s1_bright_q ? s1_rgb_q : '0;
    top_layer_d = s1_bright_q ? s1_idx_q : BG_IDX;
    sticky_d    = frame_start ? '0 : (sticky_q | hits);
    flags_d     = frame_start ? (sticky_q | hits) : flags_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q      <= '1;
      s1_rgb_q    <= '0;
      s1_idx_q    <= BG_IDX;
      s1_bright_q <= 1'b0;
      vga_rgb_q   <= '0;
      top_layer_q <= BG_IDX;
      sticky_q    <= '0;
      flags_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      s1_rgb_q    <= win_rgb;
      s1_idx_q    <= win_idx;
      s1_bright_q <= bright;
      vga_rgb_q   <= vga_rgb_d;
      top_layer_q <= top_layer_d;
      sticky_q    <= sticky_d;
      flags_q     <= flags_d;
      valid_q     <= frame_start;
    end
  end

  assign vga_rgb         = vga_rgb_q;
  assign top_layer       = top_layer_q;
  assign collision_flags = flags_q;
  assign collision_valid = valid_q;

endmodule
